jam_param: RTL and testbench

- Parametrised job-assignment engine: finds the minimum total cost of assigning N workers to N jobs, one job per worker, over all N! permutations.
- Reads the N×N cost table from an external synchronous cost ROM through W/J address ports.
- Reports MinCost, the number of optimal assignments, and the lexicographically first optimal assignment.
- Successor of the fixed 8×8 JAM engine. Adds Start/Busy handshake, parametrised N and widths, a saturating match counter and a best-permutation output.

---
 rtl/jam_param.sv | 205 ++++++++++++++++++++
 tb/tb_jam_param.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jam_param.sv
// jam_param: exhaustive job-assignment engine.
//
// Loads an N x N cost table from an external synchronous ROM (one-cycle read
// latency), then walks all N! permutations in ascending lexicographic order,
// tracking the minimum total cost, how many permutations reach it, and the
// first permutation that does.
//
// Ports:
//   CLK        rising-edge clock
//   RST_n      asynchronous active-low reset
//   Start      one-cycle search request, honoured only in IDLE
//   W, J       worker / job address to the cost ROM
//   Cost       ROM data for the W/J presented on the previous cycle
//   Busy       high while loading and searching
//   Valid      one-cycle pulse: results are final
//   MinCost    minimum total cost
//   MatchCount number of permutations reaching MinCost (saturating)
//   BestPerm   field [i*IDX_W +: IDX_W] = job given to worker i
module jam_param #(
    parameter int N      = 8,
    parameter int COST_W = 7,
    parameter int CNT_W  = 4,
    parameter int IDX_W  = (N <= 2) ? 1 : $clog2(N),
    parameter int MIN_W  = COST_W + $clog2(N)
) (
    input  logic                   CLK,
    input  logic                   RST_n,
    input  logic                   Start,
    output logic [IDX_W-1:0]       W,
    output logic [IDX_W-1:0]       J,
    input  logic [COST_W-1:0]      Cost,
    output logic                   Busy,
    output logic                   Valid,
    output logic [MIN_W-1:0]       MinCost,
    output logic [CNT_W-1:0]       MatchCount,
    output logic [N*IDX_W-1:0]     BestPerm
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_EVAL,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t state_reg, state_next;

    logic [IDX_W-1:0]  w_reg, j_reg;
    // Address of the ROM read issued last cycle; its data is on Cost now.
    logic              wr_en_reg;
    logic [IDX_W-1:0]  wr_w_reg, wr_j_reg;

    logic [COST_W-1:0] tbl_reg [N][N];
    logic [IDX_W-1:0]  perm_reg [N];
    logic [IDX_W-1:0]  perm_succ [N];
    logic [N*IDX_W-1:0] perm_flat;

    logic              first_reg;
    logic [MIN_W-1:0]  min_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [N*IDX_W-1:0] best_reg;

    logic [MIN_W-1:0]  sum_c;
    logic              is_last;
    logic [IDX_W-1:0]  piv, suc;
    logic [IDX_W-1:0]  swp [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_flat
            assign perm_flat[gi*IDX_W +: IDX_W] = perm_reg[gi];
        end
    endgenerate

    // Total cost of the current permutation; MIN_W is wide enough for N maxima.
    always_comb begin
        sum_c = '0;
        for (int i = 0; i < N; i++) begin
            sum_c = sum_c + MIN_W'(tbl_reg[i][perm_reg[i]]);
        end
    end

    // Lexicographic successor: rightmost ascent is the pivot, swap it with the
    // rightmost larger element, then reverse the tail after the pivot.
    // No ascent at all means the permutation is descending, i.e. the last one.
    always_comb begin
        is_last = 1'b1;
        piv     = '0;
        for (int k = 0; k < N - 1; k++) begin
            if (perm_reg[k] < perm_reg[k+1]) begin
                piv     = IDX_W'(k);
                is_last = 1'b0;
            end
        end
        suc = piv + 1'b1;
        for (int k = 0; k < N; k++) begin
            if ((IDX_W'(k) > piv) && (perm_reg[k] > perm_reg[piv])) begin
                suc = IDX_W'(k);
            end
        end
        swp      = perm_reg;
        swp[piv] = perm_reg[suc];
        swp[suc] = perm_reg[piv];
        for (int k = 0; k < N; k++) begin
            if (IDX_W'(k) > piv) begin
                perm_succ[k] = swp[piv + IDX_W'(N - k)];
            end else begin
                perm_succ[k] = swp[k];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (Start) state_next = S_LOAD;
            S_LOAD:  if ((w_reg == LAST_IDX) && (j_reg == LAST_IDX)) state_next = S_DRAIN;
            S_DRAIN: state_next = S_EVAL;
            S_EVAL:  state_next = is_last ? S_DONE : S_NEXT;
            S_NEXT:  state_next = S_EVAL;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_reg <= S_IDLE;
            w_reg     <= '0;
            j_reg     <= '0;
            wr_en_reg <= 1'b0;
            wr_w_reg  <= '0;
            wr_j_reg  <= '0;
            first_reg <= 1'b0;
            min_reg   <= '0;
            cnt_reg   <= '0;
            best_reg  <= '0;
            for (int i = 0; i < N; i++) perm_reg[i] <= '0;
        end else begin
            state_reg <= state_next;
            wr_en_reg <= (state_reg == S_LOAD);
            wr_w_reg  <= w_reg;
            wr_j_reg  <= j_reg;
            case (state_reg)
                S_IDLE: begin
                    if (Start) begin
                        w_reg     <= '0;
                        j_reg     <= '0;
                        min_reg   <= '0;
                        cnt_reg   <= '0;
                        best_reg  <= '0;
                        first_reg <= 1'b1;
                        for (int i = 0; i < N; i++) perm_reg[i] <= IDX_W'(i);
                    end
                end
                S_LOAD: begin
                    // Row-major walk; the final address is held afterwards.
                    if (j_reg == LAST_IDX) begin
                        if (w_reg != LAST_IDX) begin
                            j_reg <= '0;
                            w_reg <= w_reg + 1'b1;
                        end
                    end else begin
                        j_reg <= j_reg + 1'b1;
                    end
                end
                S_EVAL: begin
                    first_reg <= 1'b0;
                    if (first_reg || (sum_c < min_reg)) begin
                        min_reg  <= sum_c;
                        cnt_reg  <= CNT_W'(1);
                        best_reg <= perm_flat;
                    end else if ((sum_c == min_reg) && (cnt_reg != CNT_MAX)) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_NEXT: begin
                    perm_reg <= perm_succ;
                end
                default: ;
            endcase
        end
    end

    // Table contents are don't-care after reset, so no reset term here.
    always_ff @(posedge CLK) begin
        if (wr_en_reg) begin
            tbl_reg[wr_w_reg][wr_j_reg] <= Cost;
        end
    end

    assign W          = w_reg;
    assign J          = j_reg;
    assign Busy       = (state_reg == S_LOAD) || (state_reg == S_DRAIN) ||
                        (state_reg == S_EVAL) || (state_reg == S_NEXT);
    assign Valid      = (state_reg == S_DONE);
    assign MinCost    = min_reg;
    assign MatchCount = cnt_reg;
    assign BestPerm   = best_reg;

endmodule

// File: tb/tb_jam_param.sv
module tb_jam_param;

    logic CLK = 1'b0;
    logic RST_n = 1'b0;
    logic start_req = 1'b0;
    int   sel = 0;

    always #5 CLK = ~CLK;

    // Instance 0: N=6, CNT_W=4
    logic        start6, busy6, valid6;
    logic [2:0]  w6, j6;
    logic [6:0]  cost6;
    logic [9:0]  min6;
    logic [3:0]  cnt6;
    logic [17:0] best6;
    // Instance 1: N=3, CNT_W=4
    logic        start3, busy3, valid3;
    logic [1:0]  w3, j3;
    logic [6:0]  cost3;
    logic [8:0]  min3;
    logic [3:0]  cnt3;
    logic [5:0]  best3;
    // Instance 2: N=3, CNT_W=2
    logic        start3s, busy3s, valid3s;
    logic [1:0]  w3s, j3s;
    logic [6:0]  cost3s;
    logic [8:0]  min3s;
    logic [1:0]  cnt3s;
    logic [5:0]  best3s;

    logic [6:0] rom6 [6][6];
    logic [6:0] rom3 [3][3];

    assign start6  = start_req && (sel == 0);
    assign start3  = start_req && (sel == 1);
    assign start3s = start_req && (sel == 2);

    always @(posedge CLK) begin
        cost6  <= rom6[w6][j6];
        cost3  <= rom3[w3][j3];
        cost3s <= rom3[w3s][j3s];
    end

    jam_param #(.N(6), .COST_W(7), .CNT_W(4)) dut6 (
        .CLK(CLK), .RST_n(RST_n), .Start(start6), .W(w6), .J(j6), .Cost(cost6),
        .Busy(busy6), .Valid(valid6), .MinCost(min6), .MatchCount(cnt6), .BestPerm(best6));

    jam_param #(.N(3), .COST_W(7), .CNT_W(4)) dut3 (
        .CLK(CLK), .RST_n(RST_n), .Start(start3), .W(w3), .J(j3), .Cost(cost3),
        .Busy(busy3), .Valid(valid3), .MinCost(min3), .MatchCount(cnt3), .BestPerm(best3));

    jam_param #(.N(3), .COST_W(7), .CNT_W(2)) dut3s (
        .CLK(CLK), .RST_n(RST_n), .Start(start3s), .W(w3s), .J(j3s), .Cost(cost3s),
        .Busy(busy3s), .Valid(valid3s), .MinCost(min3s), .MatchCount(cnt3s), .BestPerm(best3s));

    logic [63:0] s_busy, s_valid, s_min, s_cnt, s_best, s_w, s_j;
    always_comb begin
        s_busy = '0; s_valid = '0; s_min = '0; s_cnt = '0; s_best = '0; s_w = '0; s_j = '0;
        case (sel)
            0: begin
                s_busy = 64'(busy6); s_valid = 64'(valid6); s_min = 64'(min6);
                s_cnt = 64'(cnt6); s_best = 64'(best6); s_w = 64'(w6); s_j = 64'(j6);
            end
            1: begin
                s_busy = 64'(busy3); s_valid = 64'(valid3); s_min = 64'(min3);
                s_cnt = 64'(cnt3); s_best = 64'(best3); s_w = 64'(w3); s_j = 64'(j3);
            end
            default: begin
                s_busy = 64'(busy3s); s_valid = 64'(valid3s); s_min = 64'(min3s);
                s_cnt = 64'(cnt3s); s_best = 64'(best3s); s_w = 64'(w3s); s_j = 64'(j3s);
            end
        endcase
    end

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic int fact(input int n);
        int f = 1;
        for (int i = 2; i <= n; i++) f = f * i;
        return f;
    endfunction

    function automatic logic [63:0] ident(input int n, input int iw);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v = v | (64'(i) << (i * iw));
        return v;
    endfunction

    task automatic rom6_fill(input bit diag);
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++)
                rom6[i][j] = (diag && (i != j)) ? 7'd10 : 7'd0;
    endtask

    task automatic rom3_fill(input bit uniform);
        int a [3][3];
        a = '{'{5, 1, 9}, '{2, 8, 3}, '{4, 6, 7}};
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                rom3[i][j] = uniform ? 7'd3 : 7'(a[i][j]);
    endtask

    // Pulses Start on instance s, checks the cleared outputs one cycle later,
    // optionally checks the W/J load order, and waits (bounded) for Valid.
    // Returns at the falling edge inside the Valid cycle.
    task automatic go(input int s, input int n, input int repulse_at, input bit chk_wj,
                      input string name);
        int bound;
        int cycles;
        bound = n * n + 4 * fact(n) + 4;
        sel = s;
        start_req = 1'b1;
        @(negedge CLK);
        start_req = 1'b0;
        cycles = 1;
        check({name, "_busy_after_start"}, s_busy, 64'd1);
        check({name, "_min_cleared"}, s_min, 64'd0);
        check({name, "_cnt_cleared"}, s_cnt, 64'd0);
        check({name, "_best_cleared"}, s_best, 64'd0);
        while (!s_valid[0] && cycles < bound) begin
            if (chk_wj && cycles <= n * n) begin
                check({name, "_W"}, s_w, 64'((cycles - 1) / n));
                check({name, "_J"}, s_j, 64'((cycles - 1) % n));
            end
            start_req = (cycles == repulse_at);
            @(negedge CLK);
            cycles++;
        end
        start_req = 1'b0;
        check({name, "_valid_within_bound"}, s_valid, 64'd1);
        check({name, "_latency"}, 64'(cycles <= bound), 64'd1);
        $display("run %s: cycles=%0d MinCost=%0d MatchCount=%0d BestPerm=0x%0h",
                 name, cycles, s_min, s_cnt, s_best);
    endtask

    int vcount;

    initial begin
        rom6_fill(1'b0);
        rom3_fill(1'b0);
        #12;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check("reset_busy", s_busy, 64'd0);
            check("reset_valid", s_valid, 64'd0);
            check("reset_min", s_min, 64'd0);
            check("reset_cnt", s_cnt, 64'd0);
            check("reset_best", s_best, 64'd0);
            check("reset_W", s_w, 64'd0);
            check("reset_J", s_j, 64'd0);
        end
        @(negedge CLK);
        RST_n = 1'b1;
        @(negedge CLK);

        // N=6, all costs zero: every permutation ties, count saturates at 15
        go(0, 6, -1, 1'b0, "n6_zero");
        check("n6_zero_min", s_min, 64'd0);
        check("n6_zero_cnt", s_cnt, 64'd15);
        check("n6_zero_best", s_best, ident(6, 3));
        @(negedge CLK);
        check("n6_zero_valid_pulse", s_valid, 64'd0);
        check("n6_zero_cnt_hold", s_cnt, 64'd15);

        // N=6, zero diagonal: identity is the unique optimum; check load order
        rom6_fill(1'b1);
        @(negedge CLK);
        go(0, 6, -1, 1'b1, "n6_diag");
        check("n6_diag_min", s_min, 64'd0);
        check("n6_diag_cnt", s_cnt, 64'd1);
        check("n6_diag_best", s_best, ident(6, 3));

        // N=3 directed table: minimum 1+3+4=8 at perm (1,2,0) -> packed 0x09.
        // A second Start is pulsed mid-search and must be ignored.
        go(1, 3, 15, 1'b0, "n3_table_repulse");
        check("n3_table_min", s_min, 64'd8);
        check("n3_table_cnt", s_cnt, 64'd1);
        check("n3_table_best", s_best, 64'h09);
        // Start during the Valid cycle is ignored
        start_req = 1'b1;
        @(negedge CLK);
        start_req = 1'b0;
        check("done_start_busy", s_busy, 64'd0);
        check("done_start_valid", s_valid, 64'd0);
        check("done_start_min_hold", s_min, 64'd8);
        check("done_start_best_hold", s_best, 64'h09);
        vcount = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (s_valid[0]) vcount++;
        end
        check("no_extra_valid", 64'(vcount), 64'd0);

        // N=3 uniform 3s: all six permutations tie at 9
        rom3_fill(1'b1);
        go(1, 3, -1, 1'b0, "n3_uniform");
        check("n3_uniform_min", s_min, 64'd9);
        check("n3_uniform_cnt", s_cnt, 64'd6);
        check("n3_uniform_best", s_best, 64'd36);
        // Start in the cycle right after Valid is accepted
        @(negedge CLK);
        go(2, 3, -1, 1'b0, "n3_uniform_cnt2");
        check("n3s_min", s_min, 64'd9);
        check("n3s_cnt_sat", s_cnt, 64'd3);
        check("n3s_best", s_best, 64'd36);

        // Asynchronous reset in the middle of the search
        rom3_fill(1'b0);
        @(negedge CLK);
        sel = 1;
        start_req = 1'b1;
        @(negedge CLK);
        start_req = 1'b0;
        repeat (12) @(negedge CLK);
        check("pre_reset_busy", s_busy, 64'd1);
        #2;
        RST_n = 1'b0;
        #1;
        check("midrst_busy", s_busy, 64'd0);
        check("midrst_valid", s_valid, 64'd0);
        check("midrst_min", s_min, 64'd0);
        check("midrst_cnt", s_cnt, 64'd0);
        check("midrst_best", s_best, 64'd0);
        check("midrst_W", s_w, 64'd0);
        check("midrst_J", s_j, 64'd0);
        @(negedge CLK);
        RST_n = 1'b1;
        vcount = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (s_valid[0] || s_busy[0]) vcount++;
        end
        check("midrst_no_resume", 64'(vcount), 64'd0);
        go(1, 3, -1, 1'b0, "n3_after_reset");
        check("after_reset_min", s_min, 64'd8);
        check("after_reset_cnt", s_cnt, 64'd1);
        check("after_reset_best", s_best, 64'h09);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
